imm_gen_queue: RTL
==================

// Module: imm_gen_queue
// PURPOSE
//  Full RV32I/RV64I immediate generator with an output queue. Decodes the immediate of every
//  base-ISA format (I, shift-I, S, B, U, J) from a 32-bit instruction and sign-/zero-extends it to XLEN.
//  Results enter a DEPTH-entry FIFO that is drained by a valid/ready consumer.
//  Sits between the IF/ID register and the ID-stage operand mux, decoupling fetch from decode stalls.
// PARAMETERS
//  XLEN   32  datapath width of imm_o; legal values 32 or 64
//  DEPTH  2   FIFO entries; power of two, >= 2
// PORTS
//  clk_i          in   1          clock, all state updates on rising edge
//  rst_i          in   1          synchronous, active-high reset
//  flush_i        in   1          discard all queued entries (branch mispredict / trap)
//  instr_i        in   32         instruction word
//  in_valid_i     in   1          instr_i valid
//  in_ready_o     out  1          queue can accept; equals !full
//  imm_o          out  XLEN       extended immediate of head entry
//  fmt_o          out  3          head format: 0 I, 1 S, 2 B, 3 U, 4 J, 5 SHAMT, 7 NONE
//  illegal_o      out  1          head opcode not recognised
//  out_valid_o    out  1          head entry valid; equals !empty
//  out_ready_i    in   1          consumer accepts head
//  count_o        out  log2(DEPTH)+1  entries currently held
// BEHAVIOUR
//  Decode (combinational, on instr_i; opcode = instr_i[6:0]):
//  - 0000011 load, 1100111 JALR, 0010011 ALU-imm with funct3 not in {001,101}:
//    I-type, imm = sext(instr[31:20]).
//  - 0010011 with funct3 001/101: SHAMT. XLEN=32: zext(instr[24:20]); XLEN=64: zext(instr[25:20]).
//    The shamt is never sign-extended; instr[30] (SRAI vs SRLI) is not part of the immediate.
//  - 0100011 store: S, sext({instr[31:25],instr[11:7]}).
//  - 1100011 branch: B, sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
//  - 0110111 LUI / 0010111 AUIPC: U, sext({instr[31:12],12'b0}); upper bits replicate instr[31] for XLEN=64.
//  - 1101111 JAL: J, sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
//  - 0110011 R-type: NONE, imm = 0, illegal = 0.
//  - Any other opcode: NONE, imm = 0, illegal = 1.
//  Queue:
//  - push = in_valid_i & in_ready_o & !flush_i; pop = out_valid_o & out_ready_i & !flush_i.
//  - Each entry stores {imm, fmt, illegal}, decoded at push time.
//  - Minimum latency 1 cycle: an entry pushed at edge N is visible on the outputs after edge N.
//    There is no combinational in->out bypass.
//  - Full: in_ready_o = 0, even if a pop occurs in the same cycle (no registered look-ahead).
//  - Empty: out_valid_o = 0; imm_o, fmt_o and illegal_o hold their last value (don't-care).
//  - Simultaneous push and pop when not full and not empty: count is unchanged and both pointers advance.
//  - Pointers wrap modulo DEPTH. count_o ranges 0..DEPTH.
//  - flush_i: at the next edge, count = 0 and rd_ptr = wr_ptr = 0.
//    A same-cycle push or pop is ignored. in_ready_o is not gated by flush_i.
//  - Reset (rst_i=1 at an edge, including mid-stream): count_o = 0, out_valid_o = 0,
//    in_ready_o = 1, imm_o = 0, fmt_o = 7, illegal_o = 0. Reset overrides flush, push and pop.
//  - No state machine beyond the pointers and count.
// TESTING
//  1 ADDI x1,x0,-1 (0xFFF00093) pushed, XLEN=32 -> next cycle out_valid_o=1, imm_o=0xFFFFFFFF, fmt_o=0.
//  2 SRAI x1,x1,31 (0x41F0D093) -> imm_o=0x0000001F, fmt_o=5. With XLEN=64, SRAI shamt 63 (0x43F0D093) -> imm_o=0x3F.
//  3 Stream SW 0xFE112E23, BEQ 0xFE000EE3, JAL 0xFFDFF0EF, LUI 0x800000B7 with out_ready_i=1
//    -> imm_o = 0xFFFFFFFC, 0xFFFFFFFC, 0xFFFFFFFC, 0x80000000 in order, one per cycle after the first.
//  4 DEPTH=2, out_ready_i=0, push 3 -> in_ready_o drops after 2, count_o=2, third not accepted.
//    Then pop and push in the same full cycle -> pop only, count_o=1.
//  5 Opcode 0x7F pushed -> illegal_o=1, fmt_o=7, imm_o=0. R-type 0x002081B3 -> illegal_o=0, fmt_o=7.
//  6 Queue holding 2 entries, assert flush_i with in_valid_i=1 -> next cycle count_o=0, out_valid_o=0.
//    Repeat with rst_i instead -> all outputs at reset values.

Source files
------------

// File: rtl/imm_gen_queue.sv
// RV32I/RV64I immediate generator feeding a DEPTH-entry FIFO drained by a valid/ready consumer.
// Each entry holds the extended immediate, its format code and an illegal-opcode flag.
module imm_gen_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic [31:0]              instr_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [XLEN-1:0]          imm_o,
    output logic [2:0]               fmt_o,
    output logic                     illegal_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] FMT_I     = 3'd0;
    localparam logic [2:0] FMT_S     = 3'd1;
    localparam logic [2:0] FMT_B     = 3'd2;
    localparam logic [2:0] FMT_U     = 3'd3;
    localparam logic [2:0] FMT_J     = 3'd4;
    localparam logic [2:0] FMT_SHAMT = 3'd5;
    localparam logic [2:0] FMT_NONE  = 3'd7;

    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_ill;
    logic [5:0]      shamt;

    always_comb begin
        dec_imm = '0;
        dec_fmt = FMT_NONE;
        dec_ill = 1'b0;
        // RV32 shifts use a 5-bit shamt; instr[25] only joins it on RV64.
        shamt   = (XLEN == 64) ? instr_i[25:20] : {1'b0, instr_i[24:20]};
        case (instr_i[6:0])
            7'b0000011, 7'b1100111: begin
                dec_fmt = FMT_I;
                dec_imm = sext32({{20{instr_i[31]}}, instr_i[31:20]});
            end
            7'b0010011: begin
                if (instr_i[13:12] == 2'b01) begin
                    dec_fmt = FMT_SHAMT;
                    dec_imm = XLEN'(shamt);
                end else begin
                    dec_fmt = FMT_I;
                    dec_imm = sext32({{20{instr_i[31]}}, instr_i[31:20]});
                end
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                dec_imm = sext32({{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]});
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                dec_imm = sext32({{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                  instr_i[30:25], instr_i[11:8], 1'b0});
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                dec_imm = sext32({instr_i[31:12], 12'b0});
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                dec_imm = sext32({{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                  instr_i[20], instr_i[30:21], 1'b0});
            end
            7'b0110011: begin
                dec_fmt = FMT_NONE;
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
    end

    logic [XLEN-1:0] imm_q [DEPTH];
    logic [2:0]      fmt_q [DEPTH];
    logic            ill_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full, empty, push, pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = in_valid_i & ~full & ~flush_i;
    assign pop   = ~empty & out_ready_i & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads as imm=0 / NONE / legal.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                imm_q[i] <= '0;
                fmt_q[i] <= FMT_NONE;
                ill_q[i] <= 1'b0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                imm_q[wr_ptr_q] <= dec_imm;
                fmt_q[wr_ptr_q] <= dec_fmt;
                ill_q[wr_ptr_q] <= dec_ill;
            end
        end
    end

    assign in_ready_o  = ~full;
    assign out_valid_o = ~empty;
    assign count_o     = count_q;
    assign imm_o       = imm_q[rd_ptr_q];
    assign fmt_o       = fmt_q[rd_ptr_q];
    assign illegal_o   = ill_q[rd_ptr_q];

endmodule
